// File: rtl/seg7_pkg.sv
// Shared types and pattern constants for the 7-segment scan capture block.
// Patterns are {a,b,c,d,e,f,g} with a as the MSB.
package seg7_pkg;

  localparam int SEG7_PAT_W = 7;

  typedef logic [SEG7_PAT_W-1:0] seg7_pat_t;

  localparam seg7_pat_t PAT_0 = 7'h7E;
  localparam seg7_pat_t PAT_1 = 7'h30;
  localparam seg7_pat_t PAT_2 = 7'h6D;
  localparam seg7_pat_t PAT_3 = 7'h79;
  localparam seg7_pat_t PAT_4 = 7'h33;
  localparam seg7_pat_t PAT_5 = 7'h5B;
  localparam seg7_pat_t PAT_6 = 7'h5F;
  localparam seg7_pat_t PAT_7 = 7'h70;
  localparam seg7_pat_t PAT_8 = 7'h7F;
  localparam seg7_pat_t PAT_9 = 7'h7B;
  localparam seg7_pat_t PAT_A = 7'h77;
  localparam seg7_pat_t PAT_B = 7'h1F;
  localparam seg7_pat_t PAT_C = 7'h4E;
  localparam seg7_pat_t PAT_D = 7'h3D;
  localparam seg7_pat_t PAT_E = 7'h4F;
  localparam seg7_pat_t PAT_F = 7'h47;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from a 7-segment pattern back to a hex nibble.
// Unknown patterns report err with hex forced to 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG7_PAT_W-1:0] pat,
  output logic [3:0]            hex,
  output logic                  err
);

  always_comb begin
    hex = 4'h0;
    err = 1'b0;
    case (pat)
      PAT_0:   hex = 4'h0;
      PAT_1:   hex = 4'h1;
      PAT_2:   hex = 4'h2;
      PAT_3:   hex = 4'h3;
      PAT_4:   hex = 4'h4;
      PAT_5:   hex = 4'h5;
      PAT_6:   hex = 4'h6;
      PAT_7:   hex = 4'h7;
      PAT_8:   hex = 4'h8;
      PAT_9:   hex = 4'h9;
      PAT_A:   hex = 4'hA;
      PAT_B:   hex = 4'hB;
      PAT_C:   hex = 4'hC;
      PAT_D:   hex = 4'hD;
      PAT_E:   hex = 4'hE;
      PAT_F:   hex = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment receive monitor: settle filter, decode, frame handoff.
// Define SEG7_CAP_ERRCNT_EN to enable the saturating err_count.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic                    dp,
  input  logic [NUM_DIGITS-1:0]   digit,
  output logic                    upd_valid,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx,
  output logic [3:0]              upd_hex,
  output logic                    upd_err,
  output logic                    frm_valid,
  input  logic                    frm_ready,
  output logic [4*NUM_DIGITS-1:0] frm_hex,
  output logic [NUM_DIGITS-1:0]   frm_dp,
  output logic [NUM_DIGITS-1:0]   frm_err,
  output logic                    overflow,
  output logic [7:0]              err_count
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = SEG7_PAT_W + 1 + NUM_DIGITS;
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [SW-1:0] smp_in;
  logic [SW-1:0] smp;
  logic          same;
  logic          onehot_in;

  seg7_state_t state;
  seg7_state_t state_n;
  logic [7:0]  cnt;
  logic [7:0]  cnt_n;
  logic [7:0]  cnt_inc;
  logic        cap;

  logic [IW-1:0]           idx;
  logic [3:0]              hex;
  logic                    err;
  logic                    dpv;
  logic [4*NUM_DIGITS-1:0] slot_hex;
  logic [NUM_DIGITS-1:0]   slot_dp;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] nx_hex;
  logic [NUM_DIGITS-1:0]   nx_dp;
  logic [NUM_DIGITS-1:0]   nx_err;
  logic                    full;
  logic                    load;

  assign smp_in    = {a, b, c, d, e, f, g, dp, digit};
  assign same      = (smp_in == smp);
  assign onehot_in = $onehot(digit);
  assign cnt_inc   = (cnt >= SC) ? SC : cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp   <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      smp   <= smp_in;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Counter value after an edge = run length of identical samples so far.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (onehot_in) begin
          state_n = SETTLE;
          cnt_n   = 8'd1;
        end else begin
          cnt_n = '0;
        end
      end
      SETTLE: begin
        if (!onehot_in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (same) begin
          cnt_n = cnt_inc;
          if (cnt_inc == SC) state_n = CAPTURED;
        end else begin
          cnt_n = 8'd1;
        end
      end
      CAPTURED: begin
        if (same) begin
          cnt_n = cnt_inc;
        end else if (onehot_in) begin
          state_n = SETTLE;
          cnt_n   = 8'd1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    cap = (state == SETTLE) && onehot_in && same && (cnt_inc == SC);
  end

  seg7_pattern_decode u_dec (
    .pat (smp[SW-1 -: SEG7_PAT_W]),
    .hex (hex),
    .err (err)
  );

  assign dpv = smp[NUM_DIGITS];

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (smp[i]) idx = IW'(i);
    end
  end

  always_comb begin
    nx_hex = slot_hex;
    nx_dp  = slot_dp;
    nx_err = slot_err;
    nx_hex[4*idx +: 4] = hex;
    nx_dp[idx]         = dpv;
    nx_err[idx]        = err;
  end

  assign full = &(seen | smp[NUM_DIGITS-1:0]);
  assign load = cap && full && (!frm_valid || frm_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_hex   <= '0;
      upd_err   <= 1'b0;
      slot_hex  <= '0;
      slot_dp   <= '0;
      slot_err  <= '0;
      seen      <= '0;
      frm_valid <= 1'b0;
      frm_hex   <= '0;
      frm_dp    <= '0;
      frm_err   <= '0;
      overflow  <= 1'b0;
    end else begin
      upd_valid <= cap;
      if (cap) begin
        upd_idx  <= idx;
        upd_hex  <= hex;
        upd_err  <= err;
        slot_hex <= nx_hex;
        slot_dp  <= nx_dp;
        slot_err <= nx_err;
        seen     <= full ? '0 : (seen | smp[NUM_DIGITS-1:0]);
      end
      if (load) begin
        frm_valid <= 1'b1;
        frm_hex   <= nx_hex;
        frm_dp    <= nx_dp;
        frm_err   <= nx_err;
      end else if (frm_valid && frm_ready) begin
        frm_valid <= 1'b0;
      end
      if (cap && full && !load) overflow <= 1'b1;
    end
  end

`ifdef SEG7_CAP_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (cap && err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side monitor for a multiplexed 7-segment display drive. It samples segment lines `a`–`g` and `dp` together with a one-hot digit select, and filters out scan glitches with a stability counter. It decodes each settled pattern back to a hex nibble and assembles a complete per-digit frame, which it hands off over a valid/ready handshake. It sits on the far side of the segment decoder, for self-check benches and on-board loopback of the display path.

## Interface
- `NUM_DIGITS`, default 4: number of scanned digits; also the width of `digit`.
- `STABLE_CYCLES`, default 4, range 2–255: number of consecutive identical samples required before a capture.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `a`, `b`, `c`, `d`, `e`, `f`, `g` input 1 each: segment lines; 1 means lit.
- `dp` input 1: decimal point; 1 means lit.
- `digit` input `NUM_DIGITS`: digit select, one-hot and active-high.
- `upd_valid` output 1: one-cycle pulse per accepted digit capture.
- `upd_idx` output `$clog2(NUM_DIGITS)`: index of the captured digit.
- `upd_hex` output 4: decoded nibble; 0 when `upd_err` is set.
- `upd_err` output 1: the captured pattern is not in the decode table.
- `frm_valid` output 1: a complete frame is held on the `frm_*` outputs.
- `frm_ready` input 1: consumer accepts the frame.
- `frm_hex` output `4*NUM_DIGITS`: digit *i* occupies bits [4*i+3:4*i].
- `frm_dp` output `NUM_DIGITS`: per-digit dp.
- `frm_err` output `NUM_DIGITS`: per-digit decode error.
- `overflow` output 1: sticky; a frame was lost while `frm_valid` was high.
- `err_count` output 8: count of invalid patterns (see Configuration).

## Operation
- **Sample register.** The pattern is P = {a,b,c,d,e,f,g}, with `a` as the MSB. Each cycle the sample register captures {P, dp, digit}.
- **Decode table.** Values in hex, for nibbles 0–F:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - Any other pattern is an error.
- **FSM state IDLE.** Entered when `digit` is not exactly one-hot (zero or multiple bits set). The stable counter is held at 0.
- **FSM state SETTLE.**
  - While the current sample equals the previous sample, the counter increments.
  - Any difference reloads the counter to 1.
  - When the counter reaches `STABLE_CYCLES`, the FSM performs a capture and moves to CAPTURED.
- **FSM state CAPTURED.** Holds with no further captures until the sample changes. It then goes to SETTLE, or to IDLE if the new select is not one-hot.
- **Capture actions.**
  - Write the nibble, dp and err bits into the digit slot; set that slot's `seen` bit.
  - Pulse `upd_*` for one cycle.
- **Frame completion.** When all `seen` bits are 1 after a capture, the slots are copied into `frm_*` and the `seen` bits are cleared.
  - If `frm_valid` is 0, or is 1 and `frm_ready` is 1 in the same cycle, the copy loads the frame and sets `frm_valid` to 1.
  - Otherwise the new frame is dropped, the held frame is unchanged, and `overflow` is set.
- **Handshake.**
  - `frm_valid` stays high and `frm_*` are stable until the cycle with `frm_ready=1`.
  - `frm_valid` clears after that cycle unless a new frame loads simultaneously.

## Timing
- **Capture latency.** Inputs stable before edge N are registered at N. `upd_valid` is high in the cycle after edge N+`STABLE_CYCLES`−1, which is `STABLE_CYCLES` cycles after the first matching sample.
- **Frame latency.** `frm_valid` rises on the same edge as the `upd_valid` of the completing capture.
- **Reset values.**
  - The FSM enters IDLE.
  - Counter, slots, `seen`, `upd_*`, `frm_*`, `overflow` and `err_count` are all 0.
- **Reset mid-operation.** All captured state is discarded, including a pending frame. `frm_valid` drops asynchronously.
- **Counter limit.** The counter saturates at `STABLE_CYCLES`, so it never wraps during long dwells.
- **dp changes.** A `dp`-only change counts as a sample change and restarts settling.

## Configuration
- `SEG7_CAP_ERRCNT_EN` defined: `err_count` increments on each capture with `upd_err=1` and saturates at 255.
- `SEG7_CAP_ERRCNT_EN` undefined: the counter logic is removed and `err_count` is tied to 0.
- The ports are identical in both builds.

## Structure
- **Package `seg7_pkg`.**
  - The 16 pattern constants and the `seg7_state_t` enum {IDLE, SETTLE, CAPTURED}.
  - The `SEG7_PAT_W=7` localparam.
- **Sub-module `seg7_pattern_decode`.** Combinational lookup from a 7-bit pattern to {hex[3:0], err}. It is instantiated once, on the sample register output.

## Test plan
- **Stable digit.** `digit`=0001, P=6D, dp=0, held for 10 cycles, `STABLE_CYCLES`=4 → exactly one `upd_valid` pulse, 4 cycles after the first sample, with `upd_idx`=0, `upd_hex`=2, `upd_err`=0.
- **Glitch rejection.** P=79 for 3 cycles, then 1 cycle of 30, then 79 for 4 cycles → no capture during the glitch; a single capture of hex 3 after the final 4 cycles.
- **Full scan.** Digits 0–3 show 7E, 30, 77, 47 with dp on digit 2, 5 cycles each, `frm_ready`=1 → `frm_hex`=16'hFA10, `frm_dp`=4'b0100, and a one-cycle `frm_valid`.
- **Backpressure.** Two full scans with `frm_ready`=0 → first frame held unchanged, `overflow`=1. Then `frm_ready`=1 for one cycle → `frm_valid` falls.
- **Invalid pattern.** P=00 on digit 1 → `upd_err`=1, `upd_hex`=0, `frm_err`[1]=1, and `err_count`=1 when `SEG7_CAP_ERRCNT_EN` is defined, 0 otherwise.
- **Reset mid-scan.** Assert `rst` mid-scan with `frm_valid`=1 → all outputs are 0 immediately. After release, a new full scan is required before `frm_valid` asserts.
